// File: rtl/id_stage_pkg.sv
// Shared ISA constants and the ALU operation encoding used by the decode stage.
// The funct-to-aluop helper keeps the R-type decode table in one place.
package id_stage_pkg;

    localparam int ALUOP_W = 5;

    typedef enum logic [ALUOP_W-1:0] {
        ALU_NOP  = 5'd0,
        ALU_ADDU = 5'd1,
        ALU_SUBU = 5'd2,
        ALU_AND  = 5'd3,
        ALU_OR   = 5'd4,
        ALU_XOR  = 5'd5,
        ALU_NOR  = 5'd6,
        ALU_SLT  = 5'd7,
        ALU_SLL  = 5'd8,
        ALU_SRL  = 5'd9,
        ALU_SRA  = 5'd10,
        ALU_LW   = 5'd11,
        ALU_SW   = 5'd12
    } aluop_t;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    function automatic aluop_t funct_to_aluop(input logic [5:0] funct);
        case (funct)
            FN_ADDU: return ALU_ADDU;
            FN_SUBU: return ALU_SUBU;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_XOR:  return ALU_XOR;
            FN_NOR:  return ALU_NOR;
            FN_SLT:  return ALU_SLT;
            FN_SLL:  return ALU_SLL;
            FN_SRL:  return ALU_SRL;
            FN_SRA:  return ALU_SRA;
            default: return ALU_NOP;
        endcase
    endfunction

endpackage

// File: rtl/id_forward.sv
// Per-source operand mux: r0, then EX result, then MEM result, then register file.
// Priority gives the youngest in-flight producer precedence.
module id_forward
    import id_stage_pkg::*;
(
    input  logic [4:0]  i_addr,
    input  logic [31:0] i_rdata,
    input  logic        i_ex_we,
    input  logic [4:0]  i_ex_addr,
    input  logic [31:0] i_ex_data,
    input  logic        i_mem_we,
    input  logic [4:0]  i_mem_addr,
    input  logic [31:0] i_mem_data,
    output logic [31:0] o_data
);

    always_comb begin
        if (i_addr == 5'd0)
            o_data = 32'd0;
        else if (i_ex_we && (i_ex_addr == i_addr))
            o_data = i_ex_data;
        else if (i_mem_we && (i_mem_addr == i_addr))
            o_data = i_mem_data;
        else
            o_data = i_rdata;
    end

endmodule

// File: rtl/id_stage.sv
// MIPS decode stage: register reads with forwarding, load-use detection,
// branch/jump resolution with one delay slot, and the ID/EX pipeline register.
module id_stage
    import id_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_inst,
    output logic        sg1,
    output logic [4:0]  raddr1,
    input  logic [31:0] rdata1,
    output logic        sg2,
    output logic [4:0]  raddr2,
    input  logic [31:0] rdata2,
    input  logic        ex_fwd_we,
    input  logic [4:0]  ex_fwd_addr,
    input  logic [31:0] ex_fwd_data,
    input  logic        ex_fwd_load,
    input  logic        mem_fwd_we,
    input  logic [4:0]  mem_fwd_addr,
    input  logic [31:0] mem_fwd_data,
    output logic        stall_req,
    output logic        branch_flag,
    output logic [31:0] branch_target,
    output logic [4:0]  id_ex_aluop,
    output logic [31:0] id_ex_op1,
    output logic [31:0] id_ex_op2,
    output logic [4:0]  id_ex_waddr,
    output logic        id_ex_we,
    output logic [31:0] id_ex_store_data,
    output logic        id_ex_delay_slot
);

    logic [5:0]  w_opcode, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
    logic [15:0] w_imm;
    logic [31:0] w_sext, w_zext, w_pc4, w_pc8, w_btarget, w_jtarget;
    logic [31:0] w_rs_val, w_rt_val;

    aluop_t      w_aluop;
    logic        w_sg1_dec, w_sg2_dec, w_sg1, w_sg2;
    logic        w_we, w_is_br, w_taken, w_stall_req;
    logic [4:0]  w_waddr;
    logic [31:0] w_op1, w_op2, w_store, w_target;

    aluop_t      r_aluop;
    logic [31:0] r_op1, r_op2, r_store;
    logic [4:0]  r_waddr;
    logic        r_we, r_ds, r_next_is_ds;

    assign w_opcode  = if_inst[31:26];
    assign w_rs      = if_inst[25:21];
    assign w_rt      = if_inst[20:16];
    assign w_rd      = if_inst[15:11];
    assign w_shamt   = if_inst[10:6];
    assign w_funct   = if_inst[5:0];
    assign w_imm     = if_inst[15:0];
    assign w_sext    = {{16{w_imm[15]}}, w_imm};
    assign w_zext    = {16'd0, w_imm};
    assign w_pc4     = if_pc + 32'd4;
    assign w_pc8     = if_pc + 32'd8;
    assign w_btarget = w_pc4 + {w_sext[29:0], 2'b00};
    assign w_jtarget = {w_pc4[31:28], if_inst[25:0], 2'b00};

    id_forward u_fwd_rs (
        .i_addr     (w_rs),
        .i_rdata    (rdata1),
        .i_ex_we    (ex_fwd_we),
        .i_ex_addr  (ex_fwd_addr),
        .i_ex_data  (ex_fwd_data),
        .i_mem_we   (mem_fwd_we),
        .i_mem_addr (mem_fwd_addr),
        .i_mem_data (mem_fwd_data),
        .o_data     (w_rs_val)
    );

    id_forward u_fwd_rt (
        .i_addr     (w_rt),
        .i_rdata    (rdata2),
        .i_ex_we    (ex_fwd_we),
        .i_ex_addr  (ex_fwd_addr),
        .i_ex_data  (ex_fwd_data),
        .i_mem_we   (mem_fwd_we),
        .i_mem_addr (mem_fwd_addr),
        .i_mem_data (mem_fwd_data),
        .o_data     (w_rt_val)
    );

    always_comb begin
        w_aluop   = ALU_NOP;
        w_sg1_dec = 1'b0;
        w_sg2_dec = 1'b0;
        w_we      = 1'b0;
        w_waddr   = 5'd0;
        w_op1     = 32'd0;
        w_op2     = 32'd0;
        w_store   = 32'd0;
        w_is_br   = 1'b0;
        w_taken   = 1'b0;
        w_target  = 32'd0;
        case (w_opcode)
            OP_SPECIAL: begin
                case (w_funct)
                    FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT: begin
                        w_aluop   = funct_to_aluop(w_funct);
                        w_sg1_dec = 1'b1;
                        w_sg2_dec = 1'b1;
                        w_we      = 1'b1;
                        w_waddr   = w_rd;
                        w_op1     = w_rs_val;
                        w_op2     = w_rt_val;
                    end
                    FN_SLL, FN_SRL, FN_SRA: begin
                        w_aluop   = funct_to_aluop(w_funct);
                        w_sg2_dec = 1'b1;
                        w_we      = 1'b1;
                        w_waddr   = w_rd;
                        w_op1     = w_rt_val;
                        w_op2     = {27'd0, w_shamt};
                    end
                    FN_JR: begin
                        w_sg1_dec = 1'b1;
                        w_is_br   = 1'b1;
                        w_taken   = 1'b1;
                        w_target  = w_rs_val;
                    end
                    default: ;
                endcase
            end
            OP_J: begin
                w_is_br  = 1'b1;
                w_taken  = 1'b1;
                w_target = w_jtarget;
            end
            OP_JAL: begin
                w_is_br  = 1'b1;
                w_taken  = 1'b1;
                w_target = w_jtarget;
                w_aluop  = ALU_ADDU;
                w_we     = 1'b1;
                w_waddr  = 5'd31;
                w_op1    = w_pc8;
            end
            OP_BEQ, OP_BNE: begin
                w_sg1_dec = 1'b1;
                w_sg2_dec = 1'b1;
                w_is_br   = 1'b1;
                w_taken   = (w_rs_val == w_rt_val) ^ (w_opcode == OP_BNE);
                w_target  = w_btarget;
            end
            OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LW: begin
                w_sg1_dec = 1'b1;
                w_we      = 1'b1;
                w_waddr   = w_rt;
                w_op1     = w_rs_val;
                case (w_opcode)
                    OP_ADDIU: begin w_aluop = ALU_ADDU; w_op2 = w_sext; end
                    OP_SLTI:  begin w_aluop = ALU_SLT;  w_op2 = w_sext; end
                    OP_ANDI:  begin w_aluop = ALU_AND;  w_op2 = w_zext; end
                    OP_ORI:   begin w_aluop = ALU_OR;   w_op2 = w_zext; end
                    OP_XORI:  begin w_aluop = ALU_XOR;  w_op2 = w_zext; end
                    default:  begin w_aluop = ALU_LW;   w_op2 = w_sext; end
                endcase
            end
            OP_LUI: begin
                w_aluop = ALU_OR;
                w_we    = 1'b1;
                w_waddr = w_rt;
                w_op2   = {w_imm, 16'd0};
            end
            OP_SW: begin
                w_aluop   = ALU_SW;
                w_sg1_dec = 1'b1;
                w_sg2_dec = 1'b1;
                w_op1     = w_rs_val;
                w_op2     = w_sext;
                w_store   = w_rt_val;
            end
            default: ;
        endcase
    end

    // Read enables are suppressed in reset so no hazard or branch can fire then.
    assign w_sg1       = w_sg1_dec & ~rst;
    assign w_sg2       = w_sg2_dec & ~rst;
    assign w_stall_req = ex_fwd_load && (ex_fwd_addr != 5'd0) &&
                         ((w_sg1 && (ex_fwd_addr == w_rs)) || (w_sg2 && (ex_fwd_addr == w_rt)));

    assign sg1           = w_sg1;
    assign sg2           = w_sg2;
    assign raddr1        = w_rs;
    assign raddr2        = w_rt;
    assign stall_req     = w_stall_req;
    assign branch_flag   = w_taken & ~w_stall_req & ~rst;
    assign branch_target = w_target;

    // A bubble leaves r_next_is_ds untouched so the slot survives the hazard.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_aluop      <= ALU_NOP;
            r_op1        <= 32'd0;
            r_op2        <= 32'd0;
            r_waddr      <= 5'd0;
            r_we         <= 1'b0;
            r_store      <= 32'd0;
            r_ds         <= 1'b0;
            r_next_is_ds <= 1'b0;
        end else if (!stall) begin
            if (w_stall_req) begin
                r_aluop <= ALU_NOP;
                r_op1   <= 32'd0;
                r_op2   <= 32'd0;
                r_waddr <= 5'd0;
                r_we    <= 1'b0;
                r_store <= 32'd0;
                r_ds    <= 1'b0;
            end else begin
                r_aluop      <= w_aluop;
                r_op1        <= w_op1;
                r_op2        <= w_op2;
                r_waddr      <= w_waddr;
                r_we         <= w_we;
                r_store      <= w_store;
                r_ds         <= r_next_is_ds;
                r_next_is_ds <= w_is_br;
            end
        end
    end

    assign id_ex_aluop      = r_aluop;
    assign id_ex_op1        = r_op1;
    assign id_ex_op2        = r_op2;
    assign id_ex_waddr      = r_waddr;
    assign id_ex_we         = r_we;
    assign id_ex_store_data = r_store;
    assign id_ex_delay_slot = r_ds;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: a table of input/expected records applied in order,
// combinational outputs checked before the edge and ID/EX checked after it.
module tb_id_stage;

    localparam logic [4:0] A_NOP = 5'd0, A_ADDU = 5'd1, A_SUBU = 5'd2, A_OR = 5'd4,
                           A_XOR = 5'd5, A_SLT = 5'd7, A_SRA = 5'd10, A_SW = 5'd12;

    logic        clk = 1'b0;
    logic        rst, stall;
    logic [31:0] if_pc, if_inst, rdata1, rdata2;
    logic        sg1, sg2;
    logic [4:0]  raddr1, raddr2;
    logic        ex_fwd_we, ex_fwd_load, mem_fwd_we;
    logic [4:0]  ex_fwd_addr, mem_fwd_addr;
    logic [31:0] ex_fwd_data, mem_fwd_data;
    logic        stall_req, branch_flag;
    logic [31:0] branch_target;
    logic [4:0]  id_ex_aluop, id_ex_waddr;
    logic [31:0] id_ex_op1, id_ex_op2, id_ex_store_data;
    logic        id_ex_we, id_ex_delay_slot;

    id_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .if_pc(if_pc), .if_inst(if_inst),
        .sg1(sg1), .raddr1(raddr1), .rdata1(rdata1),
        .sg2(sg2), .raddr2(raddr2), .rdata2(rdata2),
        .ex_fwd_we(ex_fwd_we), .ex_fwd_addr(ex_fwd_addr), .ex_fwd_data(ex_fwd_data),
        .ex_fwd_load(ex_fwd_load),
        .mem_fwd_we(mem_fwd_we), .mem_fwd_addr(mem_fwd_addr), .mem_fwd_data(mem_fwd_data),
        .stall_req(stall_req), .branch_flag(branch_flag), .branch_target(branch_target),
        .id_ex_aluop(id_ex_aluop), .id_ex_op1(id_ex_op1), .id_ex_op2(id_ex_op2),
        .id_ex_waddr(id_ex_waddr), .id_ex_we(id_ex_we), .id_ex_store_data(id_ex_store_data),
        .id_ex_delay_slot(id_ex_delay_slot)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst, stall;
        logic [31:0] pc, inst, rd1, rd2;
        logic        ex_we;
        logic [4:0]  ex_addr;
        logic [31:0] ex_data;
        logic        ex_load, mem_we;
        logic [4:0]  mem_addr;
        logic [31:0] mem_data;
        logic        e_sg1, e_sg2, e_sreq, e_bf;
        logic [31:0] e_tgt;
        logic [4:0]  e_aluop;
        logic [31:0] e_op1, e_op2;
        logic [4:0]  e_waddr;
        logic        e_we;
        logic [31:0] e_store;
        logic        e_ds;
    } vec_t;

    vec_t          tbl[$];
    logic [107:0]  exp_q[$];
    int            n_checks = 0;
    int            n_err = 0;

    function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction
    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic vec_t mk(input logic [31:0] pc, inst, rd1, rd2);
        vec_t v;
        v = '0;
        v.pc = pc; v.inst = inst; v.rd1 = rd1; v.rd2 = rd2;
        return v;
    endfunction
    function automatic vec_t comb(input vec_t vi, input logic s1, s2, sreq, bf,
                                  input logic [31:0] tgt);
        vec_t v;
        v = vi;
        v.e_sg1 = s1; v.e_sg2 = s2; v.e_sreq = sreq; v.e_bf = bf; v.e_tgt = tgt;
        return v;
    endfunction
    function automatic vec_t ex(input vec_t vi, input logic [4:0] aluop, input logic [31:0] op1, op2,
                                input logic [4:0] waddr, input logic we, input logic [31:0] store,
                                input logic ds);
        vec_t v;
        v = vi;
        v.e_aluop = aluop; v.e_op1 = op1; v.e_op2 = op2; v.e_waddr = waddr;
        v.e_we = we; v.e_store = store; v.e_ds = ds;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic apply(input int idx, input vec_t v);
        logic [107:0] e;
        rst = v.rst; stall = v.stall; if_pc = v.pc; if_inst = v.inst;
        rdata1 = v.rd1; rdata2 = v.rd2;
        ex_fwd_we = v.ex_we; ex_fwd_addr = v.ex_addr; ex_fwd_data = v.ex_data;
        ex_fwd_load = v.ex_load;
        mem_fwd_we = v.mem_we; mem_fwd_addr = v.mem_addr; mem_fwd_data = v.mem_data;
        #1;
        chk($sformatf("v%0d sg1", idx), {127'd0, sg1}, {127'd0, v.e_sg1});
        chk($sformatf("v%0d sg2", idx), {127'd0, sg2}, {127'd0, v.e_sg2});
        chk($sformatf("v%0d stall_req", idx), {127'd0, stall_req}, {127'd0, v.e_sreq});
        chk($sformatf("v%0d branch_flag", idx), {127'd0, branch_flag}, {127'd0, v.e_bf});
        if (v.e_bf)
            chk($sformatf("v%0d branch_target", idx), {96'd0, branch_target}, {96'd0, v.e_tgt});
        exp_q.push_back({v.e_aluop, v.e_op1, v.e_op2, v.e_waddr, v.e_we, v.e_store, v.e_ds});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_checks++; n_err++;
            $display("FAIL v%0d scoreboard: actual=empty required=entry", idx);
        end else begin
            e = exp_q.pop_front();
            chk($sformatf("v%0d id_ex{aluop,op1,op2,waddr,we,store,ds}", idx),
                {20'd0, id_ex_aluop, id_ex_op1, id_ex_op2, id_ex_waddr, id_ex_we,
                 id_ex_store_data, id_ex_delay_slot}, {20'd0, e});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        // Reset with ORI presented, then release.
        v = comb(mk(0, itype(6'h0D, 0, 1, 16'h1234), 0, 0), 0, 0, 0, 0, 0);
        v.rst = 1; tbl.push_back(v); tbl.push_back(v);
        v.rst = 0; v = comb(v, 1, 0, 0, 0, 0);
        tbl.push_back(ex(v, A_OR, 0, 32'h1234, 1, 1, 0, 0));
        // Forwarding priority: EX beats MEM, r0 reads as zero.
        v = mk(0, rtype(1, 2, 3, 0, 6'h21), 5, 7);
        v.ex_we = 1; v.ex_addr = 2; v.ex_data = 9; v.mem_we = 1; v.mem_addr = 2; v.mem_data = 4;
        tbl.push_back(ex(comb(v, 1, 1, 0, 0, 0), A_ADDU, 5, 9, 3, 1, 0, 0));
        v.inst = rtype(0, 2, 3, 0, 6'h21);
        tbl.push_back(ex(comb(v, 1, 1, 0, 0, 0), A_ADDU, 0, 9, 3, 1, 0, 0));
        // Load-use bubble, then MEM forward on retry.
        v = mk(0, rtype(4, 1, 5, 0, 6'h21), 32'h55, 3);
        v.ex_we = 1; v.ex_load = 1; v.ex_addr = 4; v.ex_data = 32'h77;
        tbl.push_back(ex(comb(v, 1, 1, 1, 0, 0), A_NOP, 0, 0, 0, 0, 0, 0));
        v.ex_we = 0; v.ex_load = 0; v.mem_we = 1; v.mem_addr = 4; v.mem_data = 32'hAA;
        tbl.push_back(ex(comb(v, 1, 1, 0, 0, 0), A_ADDU, 32'hAA, 3, 5, 1, 0, 0));
        // Taken BEQ, delay slot, then back to normal.
        v = mk(32'h100, itype(6'h04, 1, 2, 16'd3), 6, 6);
        tbl.push_back(ex(comb(v, 1, 1, 0, 1, 32'h110), A_NOP, 0, 0, 0, 0, 0, 0));
        v = mk(32'h104, rtype(1, 2, 6, 0, 6'h23), 10, 3);
        tbl.push_back(ex(comb(v, 1, 1, 0, 0, 0), A_SUBU, 10, 3, 6, 1, 0, 1));
        v = mk(32'h108, itype(6'h0E, 1, 7, 16'h8001), 32'hFFFF, 0);
        tbl.push_back(ex(comb(v, 1, 0, 0, 0, 0), A_XOR, 32'hFFFF, 32'h8001, 7, 1, 0, 0));
        v = mk(32'h10C, itype(6'h2B, 1, 2, 16'hFFFC), 32'h1000, 32'hDEADBEEF);
        tbl.push_back(ex(comb(v, 1, 1, 0, 0, 0), A_SW, 32'h1000, 32'hFFFFFFFC, 0, 0,
                         32'hDEADBEEF, 0));
        v = mk(32'h110, rtype(0, 2, 8, 4, 6'h03), 0, 32'h80000000);
        tbl.push_back(ex(comb(v, 0, 1, 0, 0, 0), A_SRA, 32'h80000000, 4, 8, 1, 0, 0));
        v = mk(32'h114, itype(6'h0F, 0, 9, 16'hABCD), 0, 0);
        tbl.push_back(ex(comb(v, 0, 0, 0, 0, 0), A_OR, 0, 32'hABCD0000, 9, 1, 0, 0));
        // Not-taken BNE still opens a delay slot.
        v = mk(32'h300, itype(6'h05, 1, 2, 16'hFFFE), 1, 1);
        tbl.push_back(ex(comb(v, 1, 1, 0, 0, 0), A_NOP, 0, 0, 0, 0, 0, 0));
        v = mk(32'h304, itype(6'h09, 1, 10, 16'hFFFF), 5, 0);
        tbl.push_back(ex(comb(v, 1, 0, 0, 0, 0), A_ADDU, 5, 32'hFFFFFFFF, 10, 1, 0, 1));
        // JAL, then JR with forwarded rs in its delay slot.
        v = mk(32'h200, {6'h03, 26'h40}, 0, 0);
        tbl.push_back(ex(comb(v, 0, 0, 0, 1, 32'h100), A_ADDU, 32'h208, 0, 31, 1, 0, 0));
        v = mk(32'h204, rtype(31, 0, 0, 0, 6'h08), 0, 0);
        v.ex_we = 1; v.ex_addr = 31; v.ex_data = 32'h208;
        tbl.push_back(ex(comb(v, 1, 0, 0, 1, 32'h208), A_NOP, 0, 0, 0, 0, 0, 1));
        v = mk(32'h208, rtype(1, 2, 11, 0, 6'h2A), 1, 2);
        tbl.push_back(ex(comb(v, 1, 1, 0, 0, 0), A_SLT, 1, 2, 11, 1, 0, 1));
        v = mk(32'h20C, 32'hFC000000, 0, 0);
        tbl.push_back(ex(comb(v, 0, 0, 0, 0, 0), A_NOP, 0, 0, 0, 0, 0, 0));
        // Hazard on a branch suppresses branch_flag; retry resolves taken.
        v = mk(32'h400, itype(6'h04, 4, 0, 16'd1), 0, 0);
        v.ex_we = 1; v.ex_load = 1; v.ex_addr = 4; v.ex_data = 32'h33;
        tbl.push_back(ex(comb(v, 1, 1, 1, 0, 0), A_NOP, 0, 0, 0, 0, 0, 0));
        v.ex_we = 0; v.ex_load = 0;
        tbl.push_back(ex(comb(v, 1, 1, 0, 1, 32'h408), A_NOP, 0, 0, 0, 0, 0, 0));

        rst = 1; stall = 0;
        foreach (tbl[i]) apply(i, tbl[i]);

        // JAL sits in the slot; stall for 3 cycles holds it and the pending slot.
        v = mk(32'h500, {6'h03, 26'h40}, 0, 0);
        apply(100, ex(comb(v, 0, 0, 0, 1, 32'h100), A_ADDU, 32'h508, 0, 31, 1, 0, 1));
        for (int k = 0; k < 3; k++) begin
            v = mk(32'h504, itype(6'h0D, 0, 2, 16'h55), 0, 0);
            v.stall = 1;
            apply(101 + k, ex(comb(v, 1, 0, 0, 0, 0), A_ADDU, 32'h508, 0, 31, 1, 0, 1));
        end
        v.stall = 0;
        apply(104, ex(comb(v, 1, 0, 0, 0, 0), A_OR, 0, 32'h55, 2, 1, 0, 1));
        v = mk(32'h508, rtype(1, 2, 3, 0, 6'h21), 2, 3);
        apply(105, ex(comb(v, 1, 1, 0, 0, 0), A_ADDU, 2, 3, 3, 1, 0, 0));

        // Reset discards a pending delay slot.
        v = mk(32'h600, itype(6'h04, 0, 0, 16'd0), 0, 0);
        apply(106, ex(comb(v, 1, 1, 0, 1, 32'h604), A_NOP, 0, 0, 0, 0, 0, 0));
        v = mk(32'h604, itype(6'h0D, 0, 1, 16'h7), 0, 0);
        v.rst = 1;
        apply(107, ex(comb(v, 0, 0, 0, 0, 0), A_NOP, 0, 0, 0, 0, 0, 0));
        v.rst = 0;
        apply(108, ex(comb(v, 1, 0, 0, 0, 0), A_OR, 0, 7, 1, 1, 0, 0));

        // Hazard bubble inside a delay slot keeps the slot for the retry.
        v = mk(32'h700, itype(6'h05, 1, 2, 16'd4), 1, 1);
        apply(109, ex(comb(v, 1, 1, 0, 0, 0), A_NOP, 0, 0, 0, 0, 0, 0));
        v = mk(32'h704, rtype(4, 1, 5, 0, 6'h21), 8, 9);
        v.ex_we = 1; v.ex_load = 1; v.ex_addr = 4;
        apply(110, ex(comb(v, 1, 1, 1, 0, 0), A_NOP, 0, 0, 0, 0, 0, 0));
        v.ex_we = 0; v.ex_load = 0;
        apply(111, ex(comb(v, 1, 1, 0, 0, 0), A_ADDU, 8, 9, 5, 1, 0, 1));

        if (exp_q.size() != 0) begin
            n_checks++; n_err++;
            $display("FAIL scoreboard_drain: actual=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
